// File: rtl/writeback_pkg.sv
// Shared widths and the ALU result-buffer entry type for the writeback stage.
package writeback_pkg;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO exposing every slot and its valid bit for hazard compare.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  entries
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = entries[rd_ptr];

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      valid[i] = ((i + DEPTH - 32'(rd_ptr)) % DEPTH) < 32'(count);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      entries <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= din;
        wr_ptr          <= bump(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges load returns and ALU results onto the single register-file write port
// and flags decode hazards against every register with a write in flight.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int unsigned Q = 2,
  parameter int unsigned L = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         AluValid,
  input  logic [D-1:0] AluWaddr,
  input  logic [W-1:0] AluData,
  input  logic         LdIssue,
  input  logic [D-1:0] LdWaddr,
  input  logic         LdValid,
  input  logic [W-1:0] LdData,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  input  logic [D-1:0] Rdst,
  input  logic         RdstEn,
  output logic         Stall,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         Error
);
  localparam int unsigned EW = $bits(wb_entry_t);

  logic                   ld_full, ld_empty;
  logic [D-1:0]           ld_head;
  logic [L-1:0]           ld_vld;
  logic [L-1:0][D-1:0]    ld_ent;

  logic                   alu_full, alu_empty;
  logic [EW-1:0]          alu_head_raw;
  wb_entry_t              alu_head;
  logic [Q-1:0]           alu_vld;
  logic [Q-1:0][EW-1:0]   alu_ent;

  logic                   ld_write, alu_pop, bypass, alu_push, err_set;
  logic [2**D-1:0]        busy;
  wb_entry_t              alu_in, scan;

  assign alu_in   = '{addr: AluWaddr, data: AluData};
  assign alu_head = wb_entry_t'(alu_head_raw);

  // An LdValid with no outstanding load is ignored, so the ALU path may use the port.
  assign ld_write = LdValid & ~ld_empty;
  assign alu_pop  = ~ld_write & ~alu_empty;
  assign bypass   = AluValid & alu_empty & ~ld_write;
  assign alu_push = AluValid & ~bypass;

  assign err_set = (AluValid & alu_full & ~alu_pop)
                 | (LdIssue & ld_full & ~ld_write)
                 | (LdValid & ld_empty);

  wb_fifo #(.WIDTH(D), .DEPTH(L)) u_ld_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (LdIssue),
    .pop     (LdValid),
    .din     (LdWaddr),
    .head    (ld_head),
    .full    (ld_full),
    .empty   (ld_empty),
    .valid   (ld_vld),
    .entries (ld_ent)
  );

  wb_fifo #(.WIDTH(EW), .DEPTH(Q)) u_alu_buf (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (alu_push),
    .pop     (alu_pop),
    .din     (alu_in),
    .head    (alu_head_raw),
    .full    (alu_full),
    .empty   (alu_empty),
    .valid   (alu_vld),
    .entries (alu_ent)
  );

  always_comb begin
    busy = '0;
    scan = '0;
    for (int unsigned i = 0; i < L; i++)
      if (ld_vld[i]) busy[ld_ent[i]] = 1'b1;
    for (int unsigned i = 0; i < Q; i++) begin
      scan = wb_entry_t'(alu_ent[i]);
      if (alu_vld[i]) busy[scan.addr] = 1'b1;
    end
    if (WriteEn)  busy[Waddr]    = 1'b1;
    if (AluValid) busy[AluWaddr] = 1'b1;
  end

  assign Stall = busy[RaddrA] | busy[RaddrB] | (RdstEn & busy[Rdst]) | alu_full | ld_full;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteEn <= 1'b0;
      Waddr   <= '0;
      DataIn  <= '0;
      Error   <= 1'b0;
    end else begin
      WriteEn <= ld_write | alu_pop | bypass;
      if (ld_write) begin
        Waddr  <= ld_head;
        DataIn <= LdData;
      end else if (alu_pop) begin
        Waddr  <= alu_head.addr;
        DataIn <= alu_head.data;
      end else if (bypass) begin
        Waddr  <= AluWaddr;
        DataIn <= AluData;
      end
      if (err_set) Error <= 1'b1;
    end
  end
endmodule
